hole_event_capture: RTL and testbench
=====================================

HOLE_EVENT_CAPTURE -- requirements
Module: hole_event_capture

Interface
REQ-001 Parameter N_HOLES, 8, number of hole sensors.
REQ-002 Parameter SYNC_STAGES, 2, synchroniser flops per sensor.
REQ-003 Parameter DB_CYCLES, 16, consecutive stable synced samples required to change a filtered level.
REQ-004 Parameter FIFO_DEPTH, 4, event queue entries (power of two).
REQ-005 Parameter BALLS, 8, balls loaded per game.
REQ-006 Parameter STUCK_CYCLES, 100_000_000, filtered-high cycles before a sensor is flagged stuck.
REQ-007 clk  in  1  system clock.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 sensor_raw  in  N_HOLES  asynchronous raw hole sensors, 1 = ball present.
REQ-010 arm  in  1  single-cycle pulse that starts a new game.
REQ-011 evt_valid  out  1  queue head valid.
REQ-012 evt_ready  in  1  downstream scoring stage accepts head.
REQ-013 evt_hole  out  3  index of the hole at queue head.
REQ-014 evt_onehot  out  N_HOLES  one-hot form of evt_hole.
REQ-015 balls_left  out  4  balls remaining in the current game.
REQ-016 game_empty  out  1  high when balls_left == 0.
REQ-017 overflow  out  1  sticky: a hit was lost.
REQ-018 stuck  out  N_HOLES  per-hole stuck flags.

Function
REQ-019 Each sensor SHALL pass SYNC_STAGES flops; its filtered level SHALL toggle only after DB_CYCLES consecutive synced samples differ from it; any agreeing sample clears the count.
REQ-020 A 0->1 filtered transition SHALL raise a one-cycle hit, registered on the cycle after the filtered update.
REQ-021 A hit SHALL set the hole's pending bit; each cycle the lowest-index pending bit SHALL be pushed to the FIFO and cleared, provided the FIFO is not full or is popped that same cycle.
REQ-022 A hit on a hole whose pending bit is already set SHALL be dropped and SHALL set overflow; a full FIFO otherwise holds pending bits without loss.
REQ-023 With FIFO empty and no other pending bits, a clean raw rise held stable SHALL assert evt_valid exactly SYNC_STAGES+DB_CYCLES+2 cycles later.
REQ-024 evt_valid SHALL equal FIFO non-empty; a pop occurs on evt_valid && evt_ready; evt_hole/evt_onehot SHALL be stable while evt_valid && !evt_ready.
REQ-025 Each push SHALL decrement balls_left; hits arriving when balls_left == 0 SHALL be discarded without setting overflow.
REQ-026 arm SHALL load balls_left = BALLS and clear FIFO, pending bits, overflow and stuck; a hit coincident with arm SHALL be discarded.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL never exceed FIFO_DEPTH.

Reset
REQ-028 While rst_n is low: filters and sync flops = 0, FIFO empty, evt_valid = 0, evt_hole = 0, evt_onehot = 0, balls_left = 0, game_empty = 1, overflow = 0, stuck = 0.
REQ-029 Reset mid-operation SHALL discard all queued and pending events; no event SHALL be emitted in the first cycle after release.

Configuration
REQ-030 Macro HOLE_STUCK_DETECT_EN SHALL gate stuck detection.
REQ-031 Defined: per-hole counter of consecutive filtered-high cycles; reaching STUCK_CYCLES SHALL set stuck[i] until arm or reset; hits from a stuck hole SHALL be masked.
REQ-032 Undefined: stuck SHALL be tied to 0 and no stuck counters SHALL be built; the port list is unchanged.

Structure
REQ-033 Shared package pinball_pkg SHALL hold N_HOLES, the hole-index typedef (3-bit), and the BALLS default.
REQ-034 Sub-module hole_filter (synchroniser + debounce + edge detect, one hole) SHALL be instantiated N_HOLES times; arbiter, FIFO and ball counter stay in the top.

Verification
REQ-035 arm, then a clean rise on sensor_raw[5] -> evt_valid after 20 cycles with evt_hole = 5 and evt_onehot = 8'h20; balls_left 8->7.
REQ-036 A 10-cycle glitch on sensor_raw[2] -> no event and no change to balls_left.
REQ-037 Simultaneous rises on holes 1, 4, 6 with evt_ready = 1 -> events 1, 4, 6 on consecutive cycles; balls_left = 5.
REQ-038 evt_ready = 0 and 5 hits on distinct holes -> 4 queued, 5th held pending and delivered after one pop; overflow stays 0.
REQ-039 After 8 hits, a 9th hit -> no event, game_empty = 1; a subsequent arm -> balls_left = 8.
REQ-040 With HOLE_STUCK_DETECT_EN and STUCK_CYCLES = 50, sensor_raw[0] held high -> stuck[0] = 1; a later re-rise on hole 0 yields no event.

Source files
------------

// File: rtl/pinball_pkg.sv
// Shared constants and types for the pinball hole-sensing slice.
package pinball_pkg;

   // Default number of hole sensors on the playfield.
   localparam int unsigned N_HOLES = 8;

   // Default number of balls loaded when a game is armed.
   localparam int unsigned BALLS = 8;

   // Hole indices are carried as 3-bit values through the event queue.
   localparam int unsigned HOLE_IDX_W = 3;
   typedef logic [HOLE_IDX_W-1:0] hole_idx_t;

endpackage

// File: rtl/hole_filter.sv
// One hole sensor: synchroniser chain, counting debouncer and rising-edge
// detector producing a single-cycle hit.
// Optional build macro HOLE_STUCK_DETECT_EN exposes the filtered level so the
// top can run stuck detection on it.
module hole_filter
   import pinball_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_CYCLES   = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
`ifdef HOLE_STUCK_DETECT_EN
   output logic filtered,
`endif
   output logic hit
);

   localparam int unsigned CW = $clog2(DB_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [CW-1:0]          db_cnt_q;
   logic                   filt_q;
   logic                   filt_d_q;
   logic                   hit_q;

   assign synced = sync_q[SYNC_STAGES-1];

   // Synchroniser chain for the asynchronous sensor input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   // Level only flips after DB_CYCLES consecutive disagreeing samples; any
   // agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         db_cnt_q <= '0;
         filt_q   <= 1'b0;
      end else if (synced == filt_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == CW'(DB_CYCLES - 1)) begin
         db_cnt_q <= '0;
         filt_q   <= ~filt_q;
      end else begin
         db_cnt_q <= db_cnt_q + 1'b1;
      end
   end

   // Registered rising-edge detect on the filtered level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt_d_q <= 1'b0;
         hit_q    <= 1'b0;
      end else begin
         filt_d_q <= filt_q;
         hit_q    <= filt_q & ~filt_d_q;
      end
   end

   assign hit = hit_q;
`ifdef HOLE_STUCK_DETECT_EN
   assign filtered = filt_q;
`endif

endmodule

// File: rtl/hole_event_capture.sv
// Hole event capture: per-hole filtering, pending-bit arbitration into a
// small event FIFO, and per-game ball accounting.
// Optional build macro HOLE_STUCK_DETECT_EN enables per-hole stuck detection;
// without it the stuck outputs are tied low and no counters exist.
module hole_event_capture
   import pinball_pkg::*;
#(
   parameter int unsigned N_HOLES      = pinball_pkg::N_HOLES,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned DB_CYCLES    = 16,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned BALLS        = pinball_pkg::BALLS,
   parameter int unsigned STUCK_CYCLES = 100_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_HOLES-1:0] sensor_raw,
   input  logic               arm,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [2:0]         evt_hole,
   output logic [N_HOLES-1:0] evt_onehot,
   output logic [3:0]         balls_left,
   output logic               game_empty,
   output logic               overflow,
   output logic [N_HOLES-1:0] stuck
);

   localparam int unsigned AW         = $clog2(FIFO_DEPTH);
   localparam logic [3:0]  BALLS_INIT = 4'(BALLS);

   // Elaboration-time sanity checks on the configuration.
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("hole_event_capture: FIFO_DEPTH must be a power of two >= 2");
   end
   if (SYNC_STAGES < 2 || DB_CYCLES < 1 || STUCK_CYCLES < 1) begin : g_bad_timing
      $error("hole_event_capture: SYNC_STAGES >= 2, DB_CYCLES >= 1, STUCK_CYCLES >= 1 required");
   end

   logic [N_HOLES-1:0] hit_vec;
   logic [N_HOLES-1:0] stuck_mask;
   logic [N_HOLES-1:0] hit_acc;
   logic [N_HOLES-1:0] pending_q;
   logic [N_HOLES-1:0] pending_eff;
   logic [N_HOLES-1:0] pending_nxt;
   logic               ovf_hit;
   hole_idx_t          sel_idx;
   logic               sel_found;
   logic               push;
   logic               pop;
   logic               have_balls;
   logic [3:0]         balls_q;
   logic               overflow_q;

   logic [AW:0]        wr_ptr_q;
   logic [AW:0]        rd_ptr_q;
   hole_idx_t          fifo_mem [FIFO_DEPTH];
   logic               fifo_empty;
   logic               fifo_full;

`ifdef HOLE_STUCK_DETECT_EN
   logic [N_HOLES-1:0] filt_vec;
`endif

   // Per-hole sensor conditioning.
   for (genvar g = 0; g < N_HOLES; g++) begin : g_hole
      hole_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES)
      ) u_filter (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw      (sensor_raw[g]),
`ifdef HOLE_STUCK_DETECT_EN
         .filtered (filt_vec[g]),
`endif
         .hit      (hit_vec[g])
      );
   end

`ifdef HOLE_STUCK_DETECT_EN
   localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);

   logic [N_HOLES-1:0] stuck_q;

   for (genvar g = 0; g < N_HOLES; g++) begin : g_stuck
      logic [SW-1:0] high_cnt_q;
      logic          stuck_bit_q;

      // Count consecutive filtered-high cycles; flag the hole once the count
      // reaches STUCK_CYCLES and keep the flag until arm or reset.
      always_ff @(posedge clk) begin
         if (!rst_n || arm) begin
            high_cnt_q  <= '0;
            stuck_bit_q <= 1'b0;
         end else if (filt_vec[g]) begin
            if (high_cnt_q != SW'(STUCK_CYCLES)) begin
               high_cnt_q <= high_cnt_q + 1'b1;
            end
            if (high_cnt_q == SW'(STUCK_CYCLES - 1)) begin
               stuck_bit_q <= 1'b1;
            end
         end else begin
            high_cnt_q <= '0;
         end
      end

      assign stuck_q[g] = stuck_bit_q;
   end

   assign stuck_mask = stuck_q;
   assign stuck      = stuck_q;
`else
   assign stuck_mask = '0;
   assign stuck      = '0;
`endif

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign evt_valid  = !fifo_empty;
   assign pop        = evt_valid && evt_ready;
   assign have_balls = (balls_q != '0);

   // Fresh hits are merged with pending bits before arbitration so an idle
   // queue accepts a hit in the same cycle it arrives.
   always_comb begin
      hit_acc = hit_vec & ~stuck_mask;
      if (arm || !have_balls) begin
         hit_acc = '0;
      end
      ovf_hit     = |(hit_acc & pending_q);
      pending_eff = pending_q | hit_acc;

      sel_found = 1'b0;
      sel_idx   = '0;
      for (int unsigned i = 0; i < N_HOLES; i++) begin
         if (!sel_found && pending_eff[i]) begin
            sel_found = 1'b1;
            sel_idx   = hole_idx_t'(i);
         end
      end

      push = sel_found && have_balls && !arm && (!fifo_full || pop);

      pending_nxt = pending_eff;
      if (push) begin
         pending_nxt[sel_idx] = 1'b0;
      end
      if (!have_balls) begin
         pending_nxt = '0;
      end
   end

   // Queue pointers, pending bits, ball count and sticky overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pending_q  <= '0;
         balls_q    <= '0;
         overflow_q <= 1'b0;
      end else if (arm) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pending_q  <= '0;
         balls_q    <= BALLS_INIT;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            balls_q  <= balls_q - 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         pending_q <= pending_nxt;
         if (ovf_hit) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Event storage; entries are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= sel_idx;
      end
   end

   // Head presentation, forced to zero while the queue is empty.
   always_comb begin
      evt_hole   = '0;
      evt_onehot = '0;
      if (evt_valid) begin
         evt_hole = fifo_mem[rd_ptr_q[AW-1:0]];
         for (int unsigned i = 0; i < N_HOLES; i++) begin
            if (hole_idx_t'(i) == evt_hole) begin
               evt_onehot[i] = 1'b1;
            end
         end
      end
   end

   assign balls_left = balls_q;
   assign game_empty = (balls_q == '0);
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_hole_event_capture.sv
// Scoreboard bench for hole_event_capture: stimulus pushes expected hole
// indices, a negedge monitor pops and compares on every accepted event.
module tb_hole_event_capture;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] sensor_raw = '0;
   logic       arm = 1'b0;
   logic       evt_ready = 1'b0;
   logic       evt_valid;
   logic [2:0] evt_hole;
   logic [7:0] evt_onehot;
   logic [3:0] balls_left;
   logic       game_empty;
   logic       overflow;
   logic [7:0] stuck;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int pop_cyc[$];
   int cyc = 0;
   int lat;

   always #5 clk = ~clk;

   hole_event_capture #(
      .N_HOLES      (8),
      .SYNC_STAGES  (2),
      .DB_CYCLES    (16),
      .FIFO_DEPTH   (4),
      .BALLS        (8),
      .STUCK_CYCLES (50)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sensor_raw (sensor_raw),
      .arm        (arm),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_hole   (evt_hole),
      .evt_onehot (evt_onehot),
      .balls_left (balls_left),
      .game_empty (game_empty),
      .overflow   (overflow),
      .stuck      (stuck)
   );

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
   endtask

   // Monitor: compare accepted events with the scoreboard, and check the head
   // holds still while stalled.
   logic       stall_q = 1'b0;
   logic [2:0] held_hole = '0;
   int         exp_h;

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_q <= 1'b0;
      end else begin
         if (stall_q && evt_valid) begin
            chk("hold_stable", 32'(evt_hole), 32'(held_hole));
         end
         if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got hole %0d expected none", evt_hole);
            end else begin
               exp_h = exp_q.pop_front();
               chk("evt_hole", 32'(evt_hole), 32'(exp_h));
               chk("evt_onehot", 32'(evt_onehot), 32'(1) << exp_h);
               pop_cyc.push_back(cyc);
            end
         end
         stall_q   <= evt_valid && !evt_ready;
         held_hole <= evt_hole;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick(3);
      chk("rst_evt_valid", 32'(evt_valid), 0);
      chk("rst_evt_hole", 32'(evt_hole), 0);
      chk("rst_evt_onehot", 32'(evt_onehot), 0);
      chk("rst_balls_left", 32'(balls_left), 0);
      chk("rst_game_empty", 32'(game_empty), 1);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_stuck", 32'(stuck), 0);
      rst_n = 1'b1;
      tick(2);
      chk("post_rst_valid", 32'(evt_valid), 0);
      pulse_arm();
      chk("arm_balls", 32'(balls_left), 8);
      chk("arm_game_empty", 32'(game_empty), 0);

      // Clean rise on hole 5: latency and first event
      evt_ready = 1'b1;
      exp_q.push_back(5);
      sensor_raw[5] = 1'b1;
      lat = 0;
      while (!evt_valid && lat < 40) begin
         tick(1);
         lat++;
      end
      chk("latency_hole5", 32'(lat), 20);
      chk("first_hole", 32'(evt_hole), 5);
      chk("first_onehot", 32'(evt_onehot), 32'h20);
      tick(2);
      chk("balls_after_hole5", 32'(balls_left), 7);
      sensor_raw[5] = 1'b0;
      tick(25);

      // 10-cycle glitch on hole 2
      sensor_raw[2] = 1'b1;
      tick(10);
      sensor_raw[2] = 1'b0;
      tick(30);
      chk("glitch_balls", 32'(balls_left), 7);
      chk("glitch_valid", 32'(evt_valid), 0);

      // Simultaneous rises on 1, 4, 6
      pulse_arm();
      pop_cyc.delete();
      exp_q.push_back(1);
      exp_q.push_back(4);
      exp_q.push_back(6);
      sensor_raw = 8'h52;
      tick(30);
      chk("multi_balls", 32'(balls_left), 5);
      chk("multi_pops", 32'(pop_cyc.size()), 3);
      if (pop_cyc.size() == 3) begin
         chk("multi_gap01", 32'(pop_cyc[1] - pop_cyc[0]), 1);
         chk("multi_gap12", 32'(pop_cyc[2] - pop_cyc[1]), 1);
      end
      sensor_raw = '0;
      tick(25);

      // Stalled queue: 4 queued, 5th held pending
      pulse_arm();
      evt_ready = 1'b0;
      exp_q.push_back(0);
      exp_q.push_back(2);
      exp_q.push_back(3);
      exp_q.push_back(5);
      exp_q.push_back(7);
      sensor_raw = 8'hAD;
      tick(30);
      chk("full_valid", 32'(evt_valid), 1);
      chk("full_head", 32'(evt_hole), 0);
      chk("full_balls", 32'(balls_left), 4);
      chk("full_overflow", 32'(overflow), 0);

      // Re-hit on the still-pending hole 7 is lost
      sensor_raw[7] = 1'b0;
      tick(25);
      sensor_raw[7] = 1'b1;
      tick(25);
      chk("rehit_overflow", 32'(overflow), 1);
      chk("rehit_balls", 32'(balls_left), 4);
      evt_ready = 1'b1;
      tick(10);
      chk("drain_balls", 32'(balls_left), 3);
      chk("drain_valid", 32'(evt_valid), 0);
      chk("drain_scoreboard", 32'(exp_q.size()), 0);
      chk("overflow_sticky", 32'(overflow), 1);
      sensor_raw = '0;
      tick(25);
      pulse_arm();
      chk("arm_clears_overflow", 32'(overflow), 0);

      // Use up all balls, then one more hit
      for (int i = 0; i < 8; i++) exp_q.push_back(i);
      sensor_raw = 8'hFF;
      tick(35);
      chk("empty_balls", 32'(balls_left), 0);
      chk("empty_flag", 32'(game_empty), 1);
      chk("empty_scoreboard", 32'(exp_q.size()), 0);
      sensor_raw = '0;
      tick(25);
      sensor_raw[3] = 1'b1;
      tick(30);
      chk("ninth_valid", 32'(evt_valid), 0);
      chk("ninth_balls", 32'(balls_left), 0);
      chk("ninth_overflow", 32'(overflow), 0);
      sensor_raw = '0;
      tick(25);
      pulse_arm();
      chk("rearm_balls", 32'(balls_left), 8);
      chk("rearm_game_empty", 32'(game_empty), 0);

      // Reset in the middle of queued traffic
      evt_ready = 1'b0;
      sensor_raw = 8'h42;
      tick(30);
      chk("midrst_pre_valid", 32'(evt_valid), 1);
      rst_n = 1'b0;
      sensor_raw = '0;
      exp_q.delete();
      tick(3);
      chk("midrst_valid", 32'(evt_valid), 0);
      chk("midrst_hole", 32'(evt_hole), 0);
      chk("midrst_balls", 32'(balls_left), 0);
      chk("midrst_game_empty", 32'(game_empty), 1);
      rst_n = 1'b1;
      tick(1);
      chk("release_no_event", 32'(evt_valid), 0);
      evt_ready = 1'b1;
      tick(30);
      chk("release_quiet", 32'(evt_valid), 0);

      // Hole 0 held high
      pulse_arm();
      exp_q.push_back(0);
      sensor_raw[0] = 1'b1;
      tick(100);
`ifdef HOLE_STUCK_DETECT_EN
      chk("stuck_set", 32'(stuck), 32'h01);
      chk("stuck_balls", 32'(balls_left), 7);
      sensor_raw[0] = 1'b0;
      tick(25);
      sensor_raw[0] = 1'b1;
      tick(30);
      chk("stuck_masked_balls", 32'(balls_left), 7);
      chk("stuck_masked_valid", 32'(evt_valid), 0);
      chk("stuck_held", 32'(stuck), 32'h01);
      pulse_arm();
      chk("stuck_cleared_by_arm", 32'(stuck), 0);
`else
      chk("stuck_tied_low", 32'(stuck), 0);
      chk("held_high_balls", 32'(balls_left), 7);
`endif
      sensor_raw = '0;
      tick(25);

      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
